vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
- Parametrised vending-machine controller, the successor of the fixed 1.50-coin accumulator.
- Accumulates coin credit in 50-cent units against a configurable price.
- Requests a vend from the dispenser over a req/ack handshake, then returns change as one pulse per 50-cent unit.
- Sits between the coin-validator front end and the dispenser/change-hopper drivers.

Parameters:
- PRICE, 3, product price in 50-cent units (1..MAX_CREDIT).
- MAX_CREDIT, 15, maximum credit that may be held; coins that would exceed it are rejected.
- CREDIT_W, $clog2(MAX_CREDIT+1), derived width of the credit register (localparam, not overridable).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- coin_valid  input  1  coin present this cycle
- coin  input  2  coin code: 01=50c (1 unit), 10=1€ (2 units), 11=2€ (4 units), 00=invalid
- coin_ready  output  1  controller accepts coins (IDLE or COLLECT)
- coin_reject  output  1  one-cycle pulse: coin offered while ready but not accepted
- vend_req  output  1  dispense request, held until acknowledged
- vend_ack  input  1  dispenser acknowledge
- change_pulse  output  1  one pulse = return one 50c coin
- credit  output  CREDIT_W  current credit (registered)
- busy  output  1  state is VEND or CHANGE
- cancel  input  1  refund request (present only with CANCEL_EN)

Behaviour:
- Reset: state=IDLE, credit=0, all outputs 0 except coin_ready=1. Reset mid-vend or mid-change aborts immediately; credit is lost.
- States: IDLE (credit==0), COLLECT (0<credit<PRICE), VEND, CHANGE. Registered state_q with combinational next-state; state is binary encoded.
- Coin accept: coin_valid & coin_ready & coin!=00 & credit+val<=MAX_CREDIT, where the sum is computed at CREDIT_W+1 bits.
  - On the accepting edge: credit <= credit+val.
  - Next state is VEND if the sum >= PRICE, else COLLECT.
- Coin reject: coin_valid & coin_ready & (coin==00 or overflow). coin_reject is asserted the following cycle for one cycle; credit and state are unchanged.
- Coins offered while coin_ready=0 are ignored: no reject, no credit change.
- VEND:
  - vend_req=1, coin_ready=0.
  - On vend_ack: credit <= credit-PRICE; next state CHANGE if the remainder > 0, else IDLE.
  - vend_ack outside VEND is ignored.
- CHANGE:
  - change_pulse=1 every cycle, credit decrements by 1 each cycle.
  - Moves to IDLE on the edge where credit goes 1->0.
  - Exactly (credit-PRICE) pulses are produced, back to back.
- Latency: a coin completing the price raises vend_req on the next cycle. The first change_pulse appears the cycle after the vend_ack edge.
- Outputs vend_req, change_pulse, coin_ready and busy are decoded from state_q (Moore). coin_reject is registered.

Optional Feature:
- CANCEL_EN defined:
  - cancel port exists.
  - cancel=1 in COLLECT goes to CHANGE and refunds the entire credit.
  - If cancel and an accepted coin occur in the same cycle, the coin is added first, then everything is refunded. No vend happens.
  - cancel is ignored in IDLE, VEND and CHANGE.
- CANCEL_EN undefined: no cancel port; credit below PRICE is held indefinitely.

Decomposition:
- Package vend_pkg holds:
  - the typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} vend_state_t;
  - coin code constants COIN_NONE, COIN_50, COIN_100, COIN_200;
  - the function coin_value(code) returning units.
- No sub-module; a single FSM plus credit register.

Test Plan:
- PRICE=3: coins 50c, 50c, 50c -> credit 1,2,3. vend_req rises the cycle after the third coin. Ack -> IDLE, no change_pulse.
- PRICE=3: coin 2€ -> credit 4, VEND. Ack after 5 cycles, with vend_req held throughout -> exactly 1 change_pulse, then credit=0, IDLE.
- coin=00 with coin_valid -> coin_reject for 1 cycle, credit unchanged. A coin during VEND -> ignored, no reject.
- PRICE=15, MAX_CREDIT=15, credit=13: 2€ -> rejected, credit stays 13. 1€ -> credit 15, VEND.
- Reset asserted asynchronously mid-CHANGE (credit 3) -> outputs and credit 0 immediately, IDLE, coin_ready=1.
- CANCEL_EN, PRICE=3: 1€ then cancel -> 2 consecutive change_pulse, no vend_req, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM states, coin codes and the
// coin-code to 50-cent-unit conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;
    localparam logic [1:0] COIN_200  = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_50:  return 3'd1;
            COIN_100: return 3'd2;
            COIN_200: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accumulation, vend req/ack handshake and
// change return in 50c pulses. Define CANCEL_EN to add the cancel/refund input.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter  int PRICE      = 3,
    parameter  int MAX_CREDIT = 15,
    localparam int CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    output logic                coin_ready,
    output logic                coin_reject,
    output logic                vend_req,
    input  logic                vend_ack,
`ifdef CANCEL_EN
    input  logic                cancel,
`endif
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic                ready;
    logic                offered;
    logic                accept;
    logic                cancel_req;
    logic [CREDIT_W:0]   sum;

`ifdef CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign ready   = (state_q == IDLE) || (state_q == COLLECT);
    // One extra bit so an overflowing sum is visible rather than wrapping.
    assign sum     = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin));
    assign offered = coin_valid && ready;
    assign accept  = offered && (coin != COIN_NONE) && (sum <= MAX_X);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = offered && !accept;
        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    state_d  = (sum >= PRICE_X) ? VEND : COLLECT;
                end
                // Cancel wins over a completing coin: the coin is refunded too.
                if ((state_q == COLLECT) && cancel_req) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_q > PRICE_C) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit_q != '0) begin
                    credit_d = credit_q - 1'b1;
                end
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign coin_ready   = ready;
    assign coin_reject  = reject_q;
    assign vend_req     = (state_q == VEND);
    assign change_pulse = (state_q == CHANGE);
    assign busy         = (state_q == VEND) || (state_q == CHANGE);
    assign credit       = credit_q;

endmodule
